seven_seg_scanner: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 21 ++
 rtl/seven_seg_scanner_if.sv | 27 ++
 rtl/seven_seg_scanner_seg_decoder.sv | 11 +
 rtl/seven_seg_scanner.sv | 107 ++++++++++
 tb/tb_seven_seg_scanner.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the 4-digit seven-segment scanner.
// Glyphs are active-high {a,b,c,d,e,f,g}; the decoder inverts them for the display.
package sevenseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,   // 0 1 2 3
        7'h33, 7'h5B, 7'h5F, 7'h70,   // 4 5 6 7
        7'h7F, 7'h7B, 7'h77, 7'h1F,   // 8 9 A b
        7'h4E, 7'h3D, 7'h4F, 7'h47    // C d E F
    };

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] value;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   en;
    } disp_buf_t;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle of the scanner: load strobe with value/dp/enable inputs,
// and the scanned active-low segment, decimal-point and digit-select outputs.
interface seven_seg_scanner_if;
    import sevenseg_pkg::*;

    // load is a single-cycle strobe sampled on every rising clock edge; there is
    // no ready: the scanner accepts every strobe, and the last one before a
    // frame boundary is the one displayed.
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   digs;

    modport master (
        output value, dp_in, digit_en, load,
        input  seg, dp, digs
    );

    modport slave (
        input  value, dp_in, digit_en, load,
        output seg, dp, digs
    );

endinterface

// File: rtl/seven_seg_scanner_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment lookup.
module seg_decoder
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg_n
);

    assign o_seg_n = ~GLYPH[i_nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit seven-segment driver with frame-synchronous double buffering.
// Define SEVENSEG_LZB_EN to blank leading zeros (digit 0 is always shown).
module seven_seg_scanner
    import sevenseg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    seven_seg_scanner_if.slave  bus
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    disp_buf_t     r_shadow;
    disp_buf_t     r_active;
    logic          r_pend;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [3:0]    r_digs;

    logic          w_cnt_tc;
    logic          w_frame;
    disp_buf_t     w_in;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg_n;
    logic          w_suppress;
    logic          w_lit;

    assign w_cnt_tc = (int'(r_cnt) == SCAN_DIV - 1);
    assign w_frame  = w_cnt_tc && (r_idx == 2'd3);
    assign w_in     = '{value: bus.value, dp: bus.dp_in, en: bus.digit_en};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_cnt_tc) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A load landing on the frame boundary bypasses the shadow so it shows next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_active <= '0;
            r_pend   <= 1'b0;
        end else if (bus.load) begin
            r_shadow <= w_in;
            if (w_frame) begin
                r_active <= w_in;
                r_pend   <= 1'b0;
            end else begin
                r_pend   <= 1'b1;
            end
        end else if (w_frame && r_pend) begin
            r_active <= r_shadow;
            r_pend   <= 1'b0;
        end
    end

    assign w_nibble = r_active.value[{r_idx, 2'b00} +: 4];

    seg_decoder u_dec (
        .i_nibble (w_nibble),
        .o_seg_n  (w_seg_n)
    );

`ifdef SEVENSEG_LZB_EN
    // A zero is leading only if nothing at or above it is nonzero or carries a dp.
    assign w_suppress = (r_idx != 2'd0)
                     && ((r_active.value >> {r_idx, 2'b00}) == 16'd0)
                     && ((r_active.dp >> r_idx) == 4'd0);
`else
    assign w_suppress = 1'b0;
`endif

    assign w_lit = (int'(r_cnt) >= BLANK_CYC) && r_active.en[r_idx] && !w_suppress;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg  <= SEG_OFF;
            r_dp   <= 1'b1;
            r_digs <= 4'b0000;
        end else if (w_lit) begin
            r_seg  <= w_seg_n;
            r_dp   <= ~r_active.dp[r_idx];
            r_digs <= 4'b0001 << r_idx;
        end else begin
            r_seg  <= SEG_OFF;
            r_dp   <= 1'b1;
            r_digs <= 4'b0000;
        end
    end

    assign bus.seg  = r_seg;
    assign bus.dp   = r_dp;
    assign bus.digs = r_digs;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (SCAN_DIV=8, BLANK_CYC=2) against a
// cycle-count based display model; honours SEVENSEG_LZB_EN in its expectations.
module tb_seven_seg_scanner;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * SD;

    // Active-low glyphs 0..F, {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_LO [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };
    localparam logic [11:0] DARK = {7'h7F, 1'b1, 4'b0000};

    typedef struct {
        logic [15:0] v;
        logic [3:0]  d;
        logic [3:0]  e;
    } mbuf_t;

    typedef struct packed {
        logic [15:0]     v;
        logic [3:0]      d;
        logic [3:0]      e;
        logic [3:0][6:0] seg;
        logic [3:0]      dpn;
        logic [3:0]      lit;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seven_seg_scanner_if bus ();

    seven_seg_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // model and scoreboard state
    mbuf_t       m_sh, m_act;
    bit          m_pend;
    int          cyc;
    logic [11:0] exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    bit          mon_one = 0;
    bit          saw_one = 0;
    vec_t        vec [4];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got seg=%h dp=%b digs=%b, expected seg=%h dp=%b digs=%b",
                     name, cyc, act[11:5], act[4], act[3:0], exp[11:5], exp[4], exp[3:0]);
        end
    endtask

    function automatic logic [11:0] model_out();
        int       slot_pos = cyc % SD;
        int       digit    = (cyc / SD) % 4;
        logic [3:0] nib    = 4'((m_act.v >> (4 * digit)) & 16'hF);
        bit       lit      = (slot_pos >= BC) && m_act.e[digit];
`ifdef SEVENSEG_LZB_EN
        if (digit != 0) begin
            bit leading = 1;
            for (int j = digit; j < 4; j++)
                if (((m_act.v >> (4 * j)) & 16'hF) != 0 || m_act.d[j]) leading = 0;
            if (leading) lit = 0;
        end
`endif
        if (lit) return {SEG_LO[nib], ~m_act.d[digit], 4'(1 << digit)};
        return DARK;
    endfunction

    // driver: one clock, optional load, then scoreboard compare
    task automatic tick(input bit l, input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        logic [11:0] exp_v;
        bus.load = l; bus.value = v; bus.dp_in = d; bus.digit_en = e;
        exp_q.push_back(model_out());
        if (l) begin
            m_sh = '{v, d, e};
            if (cyc % FRAME == FRAME - 1) begin m_act = m_sh; m_pend = 0; end
            else m_pend = 1;
        end else if (cyc % FRAME == FRAME - 1 && m_pend) begin
            m_act = m_sh; m_pend = 0;
        end
        cyc++;
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        check("scan", {bus.seg, bus.dp, bus.digs}, exp_v);
        if (mon_one && bus.digs != 4'b0 && bus.seg == 7'h4F) saw_one = 1;
        bus.load = 1'b0;
    endtask

    task automatic idle();
        tick(1'b0, bus.value, bus.dp_in, bus.digit_en);
    endtask

    task automatic run_until(input int phase);
        for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != phase; i++) idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_async", {bus.seg, bus.dp, bus.digs}, DARK);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("reset_hold", {bus.seg, bus.dp, bus.digs}, DARK);
        end
        m_sh = '{16'h0, 4'h0, 4'h0};
        m_act = m_sh;
        m_pend = 0;
        cyc = 0;
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    // sample each digit of the frame that has just started, mid-slot
    task automatic check_frame(input string name, input vec_t t);
        for (int k = 0; k < 4; k++) begin
            run_until(k * SD + 5);
            if (t.lit[k]) check(name, {bus.seg, bus.dp, bus.digs}, {t.seg[k], t.dpn[k], 4'(1 << k)});
            else          check(name, {bus.seg, bus.dp, bus.digs}, DARK);
        end
    endtask

    initial begin
        vec[0] = '{v: 16'h12AF, d: 4'b0000, e: 4'hF, seg: {7'h4F, 7'h12, 7'h08, 7'h38},
                   dpn: 4'b1111, lit: 4'b1111};
`ifdef SEVENSEG_LZB_EN
        vec[1] = '{v: 16'h0005, d: 4'b0100, e: 4'hF, seg: {7'h01, 7'h01, 7'h01, 7'h24},
                   dpn: 4'b1011, lit: 4'b0111};
`else
        vec[1] = '{v: 16'h0005, d: 4'b0100, e: 4'hF, seg: {7'h01, 7'h01, 7'h01, 7'h24},
                   dpn: 4'b1011, lit: 4'b1111};
`endif
        vec[2] = '{v: 16'hB3C8, d: 4'b1001, e: 4'b1011, seg: {7'h60, 7'h06, 7'h31, 7'h00},
                   dpn: 4'b0110, lit: 4'b1011};
        vec[3] = '{v: 16'h7D96, d: 4'b0010, e: 4'b0101, seg: {7'h0F, 7'h42, 7'h04, 7'h20},
                   dpn: 4'b1111, lit: 4'b0101};

        rst_n = 1'b1;
        bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.digit_en = '0;
        #1;
        do_reset();

        // dark with no load
        for (int i = 0; i < 64; i++) idle();

        // table vectors: load, wait for transfer, inspect the next frame
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, vec[i].v, vec[i].d, vec[i].e);
            run_until(FRAME - 1);
            idle();
            check_frame($sformatf("vec%0d", i), vec[i]);
        end

        // two loads in one frame: last wins, first never displayed
        run_until(5);
        mon_one = 1;
        tick(1'b1, 16'h1111, 4'h0, 4'hF);
        run_until(12);
        tick(1'b1, 16'h2222, 4'h0, 4'hF);
        run_until(FRAME - 1);
        idle();
        check_frame("last_wins", '{v: 16'h2222, d: 4'h0, e: 4'hF,
                    seg: {7'h12, 7'h12, 7'h12, 7'h12}, dpn: 4'hF, lit: 4'hF});
        mon_one = 0;
        check("no_1111", {11'd0, saw_one}, 12'd0);

        // load exactly on the frame boundary shows at digit 0 right after blanking
        run_until(FRAME - 1);
        tick(1'b1, 16'h4E07, 4'h0, 4'hF);
        idle();
        idle();
        check("boundary_blank", {bus.seg, bus.dp, bus.digs}, DARK);
        idle();
        check("boundary_first", {bus.seg, bus.dp, bus.digs}, {7'h0F, 1'b1, 4'b0001});

        // random loads at random times
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 19) == 0)
                tick(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
            else
                idle();
        end

        // reset while digit 2 is lit
        run_until(FRAME - 1);
        tick(1'b1, 16'h3210, 4'h0, 4'hF);
        run_until(2 * SD + 5);
        check("digit2_lit", {bus.seg, bus.dp, bus.digs}, {7'h12, 1'b1, 4'b0100});
        do_reset();
        for (int i = 0; i < 2 * FRAME; i++) idle();
        tick(1'b1, 16'h9876, 4'b0001, 4'hF);
        for (int i = 0; i < 3 * FRAME; i++) idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
